// File: rtl/car_sensor_pkg.sv
// Shared constants for the car-sensor capture port: register map addresses and reset defaults.
package car_sensor_pkg;

  localparam int unsigned REG_WIDTH = 32;
  localparam int unsigned DB_RESET_DEFAULT = 100;
  localparam logic [REG_WIDTH-1:0] EVCNT_MAX = 32'hFFFF_FFFF;

  localparam logic [2:0] ADDR_LEVEL  = 3'd0;
  localparam logic [2:0] ADDR_RISE   = 3'd1;
  localparam logic [2:0] ADDR_FALL   = 3'd2;
  localparam logic [2:0] ADDR_MASK   = 3'd3;
  localparam logic [2:0] ADDR_CAP    = 3'd4;
  localparam logic [2:0] ADDR_THRESH = 3'd5;
  localparam logic [2:0] ADDR_TS     = 3'd6;
  localparam logic [2:0] ADDR_EVCNT  = 3'd7;

endpackage

// File: rtl/car_sensor_debounce.sv
// One sensor channel: input synchroniser, debounce counter, debounced level and edge pulses.
module car_sensor_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_WIDTH    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pin_i,
  input  logic [DB_WIDTH-1:0] thresh_i,
  input  logic                cnt_clr_i,
  output logic                level_o,
  output logic                rise_o,
  output logic                fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [DB_WIDTH-1:0]    cnt_q, cnt_d;
  logic                   level_q, level_d, level_prev_q;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (sync_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == thresh_i) begin
      level_d = sync_s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + DB_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], pin_i};
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~level_prev_q;
  assign fall_o  = ~level_q & level_prev_q;

endmodule

// File: rtl/car_sensor_capture.sv
// Car-sensor input port: per-channel debounce, W1C edge capture, masked IRQ, Avalon-MM slave.
// Define CAR_SENSOR_TIMESTAMP_EN to add a free-running counter latched on every captured event.
module car_sensor_capture
  import car_sensor_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_WIDTH    = 16,
  parameter int unsigned DB_RESET    = DB_RESET_DEFAULT,
  parameter int unsigned TS_WIDTH    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] level_out
);

  logic                 wr_en;
  logic [WIDTH-1:0]     rise_en_q, fall_en_q, irq_mask_q;
  logic [WIDTH-1:0]     edge_cap_q, edge_cap_d;
  logic [DB_WIDTH-1:0]  db_thresh_q;
  logic [31:0]          evcnt_q, evcnt_d, readdata_q, readdata_d, ts_rd;
  logic [WIDTH-1:0]     level, rise, fall, new_edge, cap_clr;
  logic                 any_edge;
  logic                 unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    car_sensor_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_WIDTH   (DB_WIDTH)
    ) u_debounce (
      .clk_i    (clk),
      .rst_i    (reset),
      .pin_i    (in_port[i]),
      .thresh_i (db_thresh_q),
      .cnt_clr_i(wr_en && (address == ADDR_THRESH)),
      .level_o  (level[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i])
    );
  end

  assign new_edge = (rise & rise_en_q) | (fall & fall_en_q);
  assign any_edge = |new_edge;
  assign cap_clr  = (wr_en && (address == ADDR_CAP)) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    // A new edge overrides a same-cycle clear so no event is lost.
    edge_cap_d = (edge_cap_q & ~cap_clr) | new_edge;
    evcnt_d    = evcnt_q;
    if (wr_en && (address == ADDR_EVCNT)) begin
      evcnt_d = any_edge ? 32'd1 : 32'd0;
    end else if (any_edge && (evcnt_q != EVCNT_MAX)) begin
      evcnt_d = evcnt_q + 32'd1;
    end
  end

`ifdef CAR_SENSOR_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_q, ts_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_WIDTH'(1);
      if (any_edge) ts_q <= ts_cnt_q;
    end
  end

  assign ts_rd = 32'(ts_q);
`else
  assign ts_rd = '0;
`endif

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_LEVEL:  readdata_d = 32'(level);
      ADDR_RISE:   readdata_d = 32'(rise_en_q);
      ADDR_FALL:   readdata_d = 32'(fall_en_q);
      ADDR_MASK:   readdata_d = 32'(irq_mask_q);
      ADDR_CAP:    readdata_d = 32'(edge_cap_q);
      ADDR_THRESH: readdata_d = 32'(db_thresh_q);
      ADDR_TS:     readdata_d = ts_rd;
      ADDR_EVCNT:  readdata_d = evcnt_q;
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      irq_mask_q  <= '0;
      edge_cap_q  <= '0;
      db_thresh_q <= DB_WIDTH'(DB_RESET);
      evcnt_q     <= '0;
      readdata_q  <= '0;
    end else begin
      edge_cap_q <= edge_cap_d;
      evcnt_q    <= evcnt_d;
      readdata_q <= readdata_d;
      if (wr_en) begin
        case (address)
          ADDR_RISE:   rise_en_q   <= writedata[WIDTH-1:0];
          ADDR_FALL:   fall_en_q   <= writedata[WIDTH-1:0];
          ADDR_MASK:   irq_mask_q  <= writedata[WIDTH-1:0];
          ADDR_THRESH: db_thresh_q <= writedata[DB_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  assign readdata  = readdata_q;
  assign irq       = |(edge_cap_q & irq_mask_q);
  assign level_out = level;

endmodule

// File: tb/tb_car_sensor_capture.sv
// Self-checking bench for car_sensor_capture: cycle model compared every cycle plus directed checks.
module tb_car_sensor_capture;

  localparam int W   = 8;
  localparam int S   = 2;
  localparam int DBW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect, write_n;
  logic [31:0]   writedata, readdata;
  logic          irq;
  logic [W-1:0]  in_port, level_out;

  int n_total = 0;
  int n_pass  = 0;

  car_sensor_capture #(
    .WIDTH      (W),
    .SYNC_STAGES(S),
    .DB_WIDTH   (DBW),
    .DB_RESET   (100),
    .TS_WIDTH   (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .in_port   (in_port),
    .level_out (level_out)
  );

  always #5 clk = ~clk;

  // Model state: pin history, debounced levels and the software-visible registers.
  logic [W-1:0]   m_pins [S];
  logic [W-1:0]   m_level, m_prev, m_rise, m_fall, m_mask, m_cap;
  int unsigned    m_run [W];
  logic [DBW-1:0] m_thr;
  logic [31:0]    m_evcnt, m_ts, m_tscnt, m_rd;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_level);
      3'd1: return 32'(m_rise);
      3'd2: return 32'(m_fall);
      3'd3: return 32'(m_mask);
      3'd4: return 32'(m_cap);
      3'd5: return 32'(m_thr);
`ifdef CAR_SENSOR_TIMESTAMP_EN
      3'd6: return m_ts;
`else
      3'd6: return 32'd0;
`endif
      default: return m_evcnt;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < S; k++) m_pins[k] = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
    m_level = '0; m_prev = '0; m_rise = '0; m_fall = '0; m_mask = '0; m_cap = '0;
    m_thr = 16'd100; m_evcnt = 0; m_ts = 0; m_tscnt = 0; m_rd = 0;
  endtask

  // Advances the model by one clock, using the inputs that the next rising edge will sample.
  task automatic model_step();
    logic          wr;
    logic [W-1:0]  newe, seen;
    wr   = chipselect && !write_n;
    newe = (m_level & ~m_prev & m_rise) | (~m_level & m_prev & m_fall);
    m_rd = m_read(address);
    m_cap = (m_cap & ~((wr && address == 3'd4) ? writedata[W-1:0] : '0)) | newe;
    if (wr && address == 3'd7) m_evcnt = (newe != 0) ? 32'd1 : 32'd0;
    else if (newe != 0 && m_evcnt != 32'hFFFF_FFFF) m_evcnt++;
    if (newe != 0) m_ts = m_tscnt;
    m_tscnt++;
    // A level flips once the pin has disagreed with it for more than thresh samples in a row.
    seen   = m_pins[S-1];
    m_prev = m_level;
    for (int i = 0; i < W; i++) begin
      if (wr && address == 3'd5) m_run[i] = 0;
      else if (seen[i] == m_level[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] > m_thr) begin
          m_level[i] = seen[i];
          m_run[i]   = 0;
        end
      end
    end
    for (int k = S - 1; k > 0; k--) m_pins[k] = m_pins[k-1];
    m_pins[0] = in_port;
    if (wr) begin
      case (address)
        3'd1: m_rise = writedata[W-1:0];
        3'd2: m_fall = writedata[W-1:0];
        3'd3: m_mask = writedata[W-1:0];
        3'd5: m_thr  = writedata[DBW-1:0];
        default: ;
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) model_reset();
      check("level_out", 32'(level_out), 32'(m_level));
      check("irq", 32'(irq), 32'(|(m_cap & m_mask)));
      check("readdata", readdata, m_rd);
      if (!reset) model_step();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    @(posedge clk);
    #1;
    check(name, readdata, exp);
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; in_port = '0;
    tick(3);
    reset = 1'b0;
    rd_check("rst_thresh", 3'd5, 32'd100);
    rd_check("rst_level", 3'd0, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);

    // Rising edge on ch0 with thresh 3: level after SYNC_STAGES+4 edges.
    wr(3'd5, 32'd3);
    wr(3'd1, 32'h01);
    in_port[0] = 1'b1;
    tick(5);
    check("t1_level_early", 32'(level_out[0]), 32'd0);
    tick(1);
    check("t1_level_set", 32'(level_out[0]), 32'd1);
    tick(1);
    check("t1_irq_masked", 32'(irq), 32'd0);
    rd_check("t1_cap", 3'd4, 32'h01);
    wr(3'd3, 32'h01);
    check("t1_irq_on", 32'(irq), 32'd1);
    wr(3'd4, 32'h01);
    check("t1_irq_off", 32'(irq), 32'd0);
    rd_check("t1_cap_clr", 3'd4, 32'h00);

    // Glitch shorter than the threshold is rejected; a long hold is captured.
    wr(3'd5, 32'd10);
    wr(3'd1, 32'h03);
    in_port[1] = 1'b1;
    tick(5);
    in_port[1] = 1'b0;
    tick(20);
    check("t2_glitch_level", 32'(level_out[1]), 32'd0);
    rd_check("t2_glitch_cap", 3'd4, 32'h00);
    in_port[1] = 1'b1;
    tick(16);
    check("t2_hold_level", 32'(level_out[1]), 32'd1);
    rd_check("t2_hold_cap", 3'd4, 32'h02);
    wr(3'd4, 32'hFF);

    // Both edges enabled on ch2: one pulse gives two counted events.
    wr(3'd5, 32'd3);
    wr(3'd1, 32'h04);
    wr(3'd2, 32'h04);
    wr(3'd7, 32'd0);
    in_port[2] = 1'b1;
    tick(50);
    in_port[2] = 1'b0;
    tick(20);
    rd_check("t3_cap", 3'd4, 32'h04);
    rd_check("t3_evcnt", 3'd7, 32'd2);
    wr(3'd4, 32'hFF);

    // Clear of bit3 lands in the same cycle the ch3 edge is captured.
    wr(3'd1, 32'h08);
    wr(3'd3, 32'h08);
    in_port[3] = 1'b1;
    tick(6);
    wr(3'd4, 32'h08);
    check("t4_irq", 32'(irq), 32'd1);
    rd_check("t4_cap", 3'd4, 32'h08);

    // Two events on ch0 (fall) and ch5 (rise); timestamp reflects the later one.
    wr(3'd2, 32'h01);
    wr(3'd1, 32'h20);
    in_port[0] = 1'b0;
    tick(20);
    in_port[5] = 1'b1;
    tick(20);
`ifndef CAR_SENSOR_TIMESTAMP_EN
    rd_check("t5_ts_absent", 3'd6, 32'd0);
`else
    rd_check("t5_ts", 3'd6, m_ts);
`endif
    rd_check("t5_evcnt", 3'd7, 32'd5);

    // Capture all channels, then reset in the middle of a debounce.
    wr(3'd1, 32'hFF);
    wr(3'd2, 32'hFF);
    in_port = ~in_port;
    tick(12);
    rd_check("t6_cap_all", 3'd4, 32'hFF);
    wr(3'd3, 32'hFF);
    check("t6_irq_on", 32'(irq), 32'd1);
    in_port = ~in_port;
    tick(3);
    reset = 1'b1;
    #1;
    check("t6_rst_irq", 32'(irq), 32'd0);
    check("t6_rst_level", 32'(level_out), 32'd0);
    check("t6_rst_rd", readdata, 32'd0);
    @(posedge clk);
    #1;
    tick(1);
    reset = 1'b0;
    rd_check("t6_thresh", 3'd5, 32'd100);
    rd_check("t6_cap", 3'd4, 32'd0);
    rd_check("t6_evcnt", 3'd7, 32'd0);
    rd_check("t6_rise", 3'd1, 32'd0);
    tick(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
